stream_filter_pipeline: RTL

Parametrised successor to the fixed filter-plus-buffer pipeline. It accepts a ready/valid input stream, applies a per-beat selectable moving-average or bypass filter, and buffers the results in a show-ahead FIFO that drives a ready/valid output stream. Unlike its predecessor, it propagates backpressure end to end, so no sample is ever dropped. It also provides a synchronous flush, fill-level reporting and an almost-full threshold. It sits between a sample source and a downstream consumer that may stall.

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/stream_fifo.sv | 83 ++++++++
 rtl/stream_filter_pipeline.sv | 112 +++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared mode encoding and width helpers for the stream filter pipeline.
// Revision 1.0
`default_nettype none

package pipeline_pkg;

  typedef enum logic {
    MODE_AVG    = 1'b0,
    MODE_BYPASS = 1'b1
  } filt_mode_e;

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int sum_width(input int data_width, input int taps);
    return data_width + $clog2(taps);
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_fifo.sv
// stream_fifo: show-ahead circular FIFO with flush, occupancy and almost-full status.
// Revision 1.0
`default_nettype none

module stream_fifo
  import pipeline_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = 6,
  parameter int LVL_W       = level_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty,
  output logic             almost_full
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AFULL_L = LVL_W'(AFULL_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full        = (level_q == DEPTH_L);
  assign empty       = (level_q == '0);
  assign almost_full = (level_q >= AFULL_L);
  assign level       = level_q;
  assign pop_data    = empty ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/stream_filter_pipeline.sv
// stream_filter_pipeline: moving-average/bypass filter feeding a show-ahead FIFO, full backpressure.
// Revision 1.0
`default_nettype none

module stream_filter_pipeline
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int TAPS        = 4,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       mode,
  input  logic                       flush,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full
);

  localparam int TAPS_LOG2 = $clog2(TAPS);
  localparam int SUM_W     = sum_width(DATA_WIDTH, TAPS);
  localparam int LVL_W     = level_width(DEPTH);

  logic [DATA_WIDTH-1:0] hist_q [TAPS-1];
  logic [DATA_WIDTH-1:0] hist_d [TAPS-1];
  logic [DATA_WIDTH-1:0] fdata_q, fdata_d;
  logic                  fv_q, fv_d;
  logic [SUM_W-1:0]      sum;
  logic [DATA_WIDTH-1:0] result;
  logic                  accept, pop, push_ok, push;
  logic                  fifo_full, fifo_empty;

  assign pop       = !fifo_empty && out_ready;
  assign push_ok   = !fifo_full || pop;
  assign push      = fv_q && push_ok;
  assign in_ready  = !flush && (!fv_q || push_ok);
  assign accept    = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign full      = fifo_full;
  assign empty     = fifo_empty;

  always_comb begin
    sum = SUM_W'(in_data);
    for (int i = 0; i < TAPS - 1; i++) begin
      sum = sum + SUM_W'(hist_q[i]);
    end
    result = (filt_mode_e'(mode) == MODE_BYPASS) ? in_data : DATA_WIDTH'(sum >> TAPS_LOG2);
  end

  always_comb begin
    hist_d  = hist_q;
    fdata_d = fdata_q;
    fv_d    = fv_q;
    if (flush) begin
      for (int i = 0; i < TAPS - 1; i++) hist_d[i] = '0;
      fv_d = 1'b0;
    end else begin
      // History advances in both modes so averaging resumes without a warm-up gap.
      if (accept) begin
        hist_d[0] = in_data;
        for (int i = 1; i < TAPS - 1; i++) hist_d[i] = hist_q[i-1];
        fdata_d = result;
        fv_d    = 1'b1;
      end else if (push) begin
        fv_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS - 1; i++) hist_q[i] <= '0;
      fdata_q <= '0;
      fv_q    <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fdata_q <= fdata_d;
      fv_q    <= fv_d;
    end
  end

  stream_fifo #(
    .WIDTH       (DATA_WIDTH),
    .DEPTH       (DEPTH),
    .AFULL_LEVEL (AFULL_LEVEL),
    .LVL_W       (LVL_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .push        (push),
    .push_data   (fdata_q),
    .pop         (pop),
    .pop_data    (out_data),
    .level       (level),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .almost_full (almost_full)
  );

endmodule

`default_nettype wire
